// File: rtl/adc_scan_ctrl.sv
// Scanning controller for an external A/D chip with an input mux: converts each
// enabled channel in ascending order (single pass or continuous) and hands results out over valid/ready.
module adc_scan_ctrl #(
    parameter int DATA_W   = 12,
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2,
    parameter int SETTLE   = 4,
    parameter int READ_HLD = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              ad_status,
    input  logic [DATA_W-1:0] ad_data,
    output logic [CH_W-1:0]   ad_mux,
    output logic              ad_rwb,
    output logic              ad_cseb,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_CONV_WAIT,
        S_READ,
        S_OUTPUT,
        S_NEXT
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [CH_W-1:0]     mux_q, mux_d;
    logic                rwb_q, rwb_d;
    logic                cseb_q, cseb_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                terr_q, terr_d;

    logic [CH_W-1:0]     start_ch;
    logic [CH_W-1:0]     wrap_ch;
    logic [CH_W-1:0]     up_ch;
    logic                up_found;
    logic                cnt_timeout;

    // Channel selection: lowest bit of the incoming mask, lowest bit of the
    // latched mask, and lowest latched bit strictly above the current channel.
    always_comb begin
        start_ch = '0;
        wrap_ch  = '0;
        up_ch    = '0;
        up_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) start_ch = CH_W'(i);
            if (mask_q[i]) wrap_ch = CH_W'(i);
            if (mask_q[i] && (i > int'(mux_q))) begin
                up_ch    = CH_W'(i);
                up_found = 1'b1;
            end
        end
    end

    assign cnt_timeout = (cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        mode_d  = mode_q;
        mask_d  = mask_q;
        mux_d   = mux_q;
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        terr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (ch_mask != '0)) begin
                    mode_d  = mode;
                    mask_d  = ch_mask;
                    mux_d   = start_ch;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 16'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end
            end
            // The timeout counter keeps running across SAMPLE -> CONV_WAIT and
            // wins over a status edge arriving on the same cycle.
            S_SAMPLE: begin
                if (cnt_timeout) begin
                    terr_d  = 1'b1;
                    state_d = S_NEXT;
                end else if (ad_status) begin
                    state_d = S_CONV_WAIT;
                end
            end
            S_CONV_WAIT: begin
                if (cnt_timeout) begin
                    terr_d  = 1'b1;
                    state_d = S_NEXT;
                end else if (!ad_status) begin
                    cnt_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (cnt_q == 16'(READ_HLD - 1)) begin
                    data_d  = ad_data;
                    ch_d    = mux_q;
                    valid_d = 1'b1;
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                cnt_d = '0;
                if (up_found) begin
                    mux_d   = up_ch;
                    state_d = S_SETTLE;
                end else if (mode_q) begin
                    mux_d   = wrap_ch;
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered from the state being entered so they line up with it.
        case (state_d)
            S_SAMPLE: begin
                rwb_d  = 1'b0;
                cseb_d = 1'b0;
            end
            S_READ: begin
                rwb_d  = 1'b1;
                cseb_d = 1'b0;
            end
            default: begin
                rwb_d  = 1'b1;
                cseb_d = 1'b1;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            mask_q  <= '0;
            mux_q   <= '0;
            rwb_q   <= 1'b1;
            cseb_q  <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            mux_q   <= mux_d;
            rwb_q   <= rwb_d;
            cseb_q  <= cseb_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            terr_q  <= terr_d;
        end
    end

    assign ad_mux      = mux_q;
    assign ad_rwb      = rwb_q;
    assign ad_cseb     = cseb_q;
    assign busy        = busy_q;
    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_ch      = ch_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: a behavioural A/D chip model plus a table of scan
// scenarios with hand-computed result sequences, and hand-written reset/start sequences.
module tb_adc_scan_ctrl;

    localparam int DATA_W  = 12;
    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int TIMEOUT = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              mode;
    logic [NUM_CH-1:0] ch_mask;
    logic              ad_status;
    logic [DATA_W-1:0] ad_data;
    logic [CH_W-1:0]   ad_mux;
    logic              ad_rwb;
    logic              ad_cseb;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;
    int stuck_ch = -1;
    logic [DATA_W-1:0] chan_val [NUM_CH];

    adc_scan_ctrl #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W),
        .SETTLE(4), .READ_HLD(2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .ch_mask(ch_mask),
        .ad_status(ad_status), .ad_data(ad_data), .ad_mux(ad_mux), .ad_rwb(ad_rwb),
        .ad_cseb(ad_cseb), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Chip model: a SAMPLE strobe starts a conversion; STS stays high 3 cycles
    // and the data bus carries the selected channel's value.
    initial begin
        int conv_left;
        conv_left = 0;
        ad_status = 1'b0;
        ad_data   = '0;
        forever begin
            @(posedge clk);
            #2;
            if (conv_left > 0) begin
                conv_left--;
                if (conv_left == 0) ad_status = 1'b0;
            end else if (!ad_cseb && !ad_rwb && !ad_status && int'(ad_mux) != stuck_ch) begin
                ad_status = 1'b1;
                ad_data   = chan_val[ad_mux];
                conv_left = 3;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_strobes"}, 64'({ad_rwb, ad_cseb}), 64'b11);
        chk({nm, "_mux_busy"}, 64'({ad_mux, busy}), 64'd0);
        chk({nm, "_out"}, 64'({out_valid, out_data, out_ch, timeout_err}), 64'd0);
    endtask

    task automatic run_scan(input logic md, input logic [3:0] msk, input int stk,
                            input int lat, input logic poke, input int exp_n,
                            input logic [7:0] chs, input int exp_terr,
                            input int stop_after, input string nm);
        int got, terr, cyc, samp_cyc;
        logic prev_samp, done;
        logic [CH_W-1:0] c0, ec;
        logic [DATA_W-1:0] d0;
        got = 0; terr = 0; cyc = 0; samp_cyc = 0; prev_samp = 1'b0; done = 1'b0;
        stuck_ch = stk;
        mode = md; ch_mask = msk; start = 1'b1;
        step();
        start = 1'b0; mode = 1'b0; ch_mask = '0;
        chk({nm, "_busy_after_start"}, 64'(busy), 64'd1);
        while (!done && cyc < 3000) begin
            step();
            cyc++;
            if (!ad_cseb && !ad_rwb && !prev_samp) samp_cyc = cyc;
            prev_samp = !ad_cseb && !ad_rwb;
            if (timeout_err) begin
                terr++;
                chk({nm, "_timeout_latency"}, 64'(cyc - samp_cyc), 64'(TIMEOUT));
            end
            if (out_valid) begin
                if (got >= exp_n) begin
                    chk({nm, "_extra_result"}, 64'(got), 64'(exp_n - 1));
                end else begin
                    ec = chs[2*got +: 2];
                    chk({nm, "_ch"}, 64'(out_ch), 64'(ec));
                    chk({nm, "_data"}, 64'(out_data), 64'(chan_val[ec]));
                end
                c0 = out_ch; d0 = out_data;
                for (int k = 0; k < lat; k++) begin
                    if (poke && k == 1) begin
                        start = 1'b1; ch_mask = 4'hF; mode = 1'b1;
                    end
                    step();
                    cyc++;
                    start = 1'b0; ch_mask = '0; mode = 1'b0;
                    chk({nm, "_stall_hold"}, 64'({out_valid, out_ch, out_data, ad_cseb}),
                        64'({1'b1, c0, d0, 1'b1}));
                end
                out_ready = 1'b1;
                step();
                cyc++;
                out_ready = 1'b0;
                chk({nm, "_valid_drop"}, 64'(out_valid), 64'd0);
                got++;
                if (stop_after != 0 && got == stop_after) done = 1'b1;
            end
            if (!busy) done = 1'b1;
        end
        if (!done) chk({nm, "_cycle_budget"}, 64'(cyc), 64'd0);
        chk({nm, "_result_count"}, 64'(got), 64'(exp_n));
        chk({nm, "_timeout_count"}, 64'(terr), 64'(exp_terr));
        if (stop_after == 0) chk({nm, "_idle_at_end"}, 64'({busy, ad_cseb}), 64'b01);
    endtask

    typedef struct {
        logic       md;
        logic [3:0] msk;
        int         stk;
        int         lat;
        logic       poke;
        int         exp_n;
        logic [7:0] chs;
        int         exp_terr;
        string      nm;
    } vec_t;

    vec_t vt [7];

    initial begin
        int wait_cyc;
        vt[0] = '{1'b0, 4'b0100, -1, 0,  1'b0, 1, 8'b00_00_00_10, 0, "single_ch2"};
        vt[1] = '{1'b0, 4'b1011, -1, 0,  1'b0, 3, 8'b00_11_01_00, 0, "mask_1011"};
        vt[2] = '{1'b0, 4'b0100, -1, 10, 1'b0, 1, 8'b00_00_00_10, 0, "ready_stall"};
        vt[3] = '{1'b0, 4'b0011, 1,  0,  1'b0, 1, 8'b00_00_00_00, 1, "timeout_ch1"};
        vt[4] = '{1'b0, 4'b1111, -1, 1,  1'b0, 4, 8'b11_10_01_00, 0, "all_ch"};
        vt[5] = '{1'b0, 4'b0100, -1, 5,  1'b1, 1, 8'b00_00_00_10, 0, "start_while_busy"};
        vt[6] = '{1'b0, 4'b1000, -1, 0,  1'b0, 1, 8'b00_00_00_11, 0, "single_ch3"};

        chan_val[0] = 12'h5A1; chan_val[1] = 12'h3C7;
        chan_val[2] = 12'hABC; chan_val[3] = 12'hF02;
        reset = 1'b1; start = 1'b0; mode = 1'b0; ch_mask = '0; out_ready = 1'b0;
        step(); step();
        chk_reset_outputs("reset");
        reset = 1'b0;
        step();

        // start with an empty mask is ignored
        start = 1'b1; ch_mask = 4'b0000;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("empty_mask_idle", 64'({busy, ad_rwb, ad_cseb}), 64'b011);
            step();
        end

        for (int v = 0; v < 7; v++) begin
            run_scan(vt[v].md, vt[v].msk, vt[v].stk, vt[v].lat, vt[v].poke,
                     vt[v].exp_n, vt[v].chs, vt[v].exp_terr, 0, vt[v].nm);
            step();
        end

        // Continuous 0,3,0,3 then reset while waiting on a conversion.
        run_scan(1'b1, 4'b1001, -1, 0, 1'b0, 4, 8'b11_00_11_00, 0, 4, "continuous");
        wait_cyc = 0;
        while (!(busy && ad_cseb && ad_rwb && ad_status) && wait_cyc < 200) begin
            step();
            wait_cyc++;
        end
        chk("reach_conv_wait", 64'(wait_cyc < 200), 64'd1);
        reset = 1'b1;
        step();
        chk_reset_outputs("mid_conv_reset");
        reset = 1'b0;
        repeat (4) step();
        run_scan(1'b0, 4'b0010, -1, 0, 1'b0, 1, 8'b00_00_00_01, 0, 0, "restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
